delayed_op_dut: RTL and testbench
=================================

# delayed_op_dut

Parametrised register-mapped test block: two operand FIFOs (A, B) feed a programmable-delay combine engine that pushes op(A,B) into a result FIFO (Y). Successor to the fixed 1-bit OR/fixed-delay block, adding data width, FIFO depth, runtime delay and runtime operation select, plus sticky overflow status. Sits behind the bench's simple address/enable bus as a latency-checking target.

## Interface
- WIDTH, 8, data width of operands, result and read_data.
- DEPTH, 4, entries per FIFO (A, B, Y); power of two, ≥2.
- CNT_W, 8, width of delay register and delay counter.
- DELAY_RST, 50, reset value of DELAY register (must fit CNT_W).
- CLK  input  1  clock, all state on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- write_address  input  3  write register select.
- write_data  input  WIDTH  write payload.
- write_en  input  1  write strobe, one write per cycle.
- write_rdy  output  1  constant 1.
- read_address  input  3  read register select.
- read_en  input  1  read strobe (side effects only at addr 3 and 6).
- read_data  output  WIDTH  combinational read mux, zero-extended.
- read_rdy  output  1  constant 1.

## Operation
- Write map: 4 push A; 5 push B; 6 DELAY ← write_data[CNT_W-1:0] (zero-extended if WIDTH<CNT_W); 7 MODE ← write_data[1:0]; 0–3 ignored.
- Push to full A/B dropped, sets sticky ovf_a/ovf_b.
- MODE: 0 OR, 1 AND, 2 XOR, 3 ADD modulo 2^WIDTH (carry discarded).
- Read map: 0 A not full; 1 B not full; 2 Y not empty; 3 Y head (0 if empty), read_en pops if not empty; 4 DELAY; 5 MODE; 6 {ovf_a, ovf_b, busy} at bits [2:0], read_en clears ovf_a/ovf_b; 7 per Configuration.
- busy = FSM not IDLE.
- FSM: IDLE → WAIT when A and B both non-empty; counter ← 0.
- WAIT: counter increments, saturating at all-ones; fire when counter ≥ DELAY and Y not full.
- Fire: pop A and B, push Y = op(A head, B head) with current MODE, counter ← 0, → IDLE.
- Y full at fire point: hold in WAIT, counter keeps saturating, fire when Y drains.
- DELAY/MODE writes during WAIT take effect immediately (live compare; MODE sampled at fire).
- Write to A or B in same cycle as fire: pop and push both performed, occupancy unchanged.
- Push on a full FIFO still dropped even if the same cycle pops it.
- Y pop and fire in same cycle permitted when Y not full before the edge.
- Overflow set and clear-by-read in same cycle: set wins.

## Timing
- Reset (RST_N low at edge): FIFOs empty, DELAY=DELAY_RST, MODE=0, FSM IDLE, counter 0, flags 0, stats 0.
- After reset: write_rdy=1, read_rdy=1; read_data=1 at addr 0/1, 0 at addr 2/3/6/7, DELAY_RST at 4, 0 at 5.
- Reset mid-operation discards all FIFO contents and in-flight WAIT; no partial push.
- Latency: both operands present after edge t → IDLE→WAIT at edge t+1 → fire at edge t+2+DELAY; Y not-empty visible after that edge (DELAY=0 → 2 cycles).
- Back-to-back: after fire, next WAIT entry at following edge; max throughput one result per DELAY+2 cycles.
- read_data combinational from read_address and state; pops/clears occur at the edge with read_en high.

## Configuration
- DELAYED_OP_STATS_EN defined: read addr 7 returns a WIDTH-bit count of results fired since reset, saturating at all-ones, cleared only by reset.
- Undefined: counter not built; read addr 7 returns 0.

## Test plan
- Reset then read addrs 0–7 → 1,1,0,0,50,0,0,0.
- DELAY=0, MODE=0; write A=0x0F, B=0xF0 → addr2 reads 1 exactly 2 cycles after second write edge; addr3 pop reads 0xFF; then addr2=0.
- DELAY=10, MODE=3; A=0xC8, B=0x64 → result 0x2C appears 12 cycles after operands present; addr6 busy=1 during wait.
- Push 5 values into A (DEPTH=4) with B empty → addr0=0 after 4th, addr6 reads 0b100; second read of addr6 reads 0.
- Fill Y with 4 results (MODE=2), queue a 5th operand pair → busy stays 1, no push; one addr3 pop → 5th result pushed next cycle, order preserved.
- With DELAYED_OP_STATS_EN: 3 fires → addr7=3; without macro addr7=0.

Source files
------------

// File: rtl/delayed_op_dut.sv
// delayed_op_dut: register-mapped latency test block. Operand FIFOs A and B
// feed a programmable-delay engine that pushes op(A,B) into result FIFO Y.
// Optional feature macro: DELAYED_OP_STATS_EN (fired-result counter at read addr 7).

// Small synchronous FIFO; push to full and pop from empty are ignored.
module delayed_op_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module delayed_op_dut #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DELAY_RST = 50
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [2:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy
);
  localparam int unsigned EXT_W = (WIDTH > CNT_W) ? WIDTH : CNT_W;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] delay;
  logic [1:0]       mode;
  logic [CNT_W-1:0] cnt;
  logic             ovf_a;
  logic             ovf_b;
  logic             busy;
  logic             fire;

  logic             a_push, b_push, y_pop;
  logic             delay_wr, mode_wr, ovf_clr;
  logic [WIDTH-1:0] a_head, b_head, y_head, y_data;
  logic             a_full, a_empty, b_full, b_empty, y_full, y_empty;
  logic [EXT_W-1:0] wdata_ext;
  logic [EXT_W-1:0] delay_ext;
  logic [WIDTH-1:0] stats_val;

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  assign a_push   = write_en && (write_address == 3'd4);
  assign b_push   = write_en && (write_address == 3'd5);
  assign delay_wr = write_en && (write_address == 3'd6);
  assign mode_wr  = write_en && (write_address == 3'd7);
  assign y_pop    = read_en && (read_address == 3'd3);
  assign ovf_clr  = read_en && (read_address == 3'd6);

  // Width-neutral bridge between WIDTH-bit bus and CNT_W-bit delay register
  assign wdata_ext = EXT_W'(write_data);
  assign delay_ext = EXT_W'(delay);

  delayed_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk(CLK), .rst_n(RST_N), .push(a_push), .push_data(write_data),
    .pop(fire), .head(a_head), .full(a_full), .empty(a_empty)
  );

  delayed_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk(CLK), .rst_n(RST_N), .push(b_push), .push_data(write_data),
    .pop(fire), .head(b_head), .full(b_full), .empty(b_empty)
  );

  delayed_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_y (
    .clk(CLK), .rst_n(RST_N), .push(fire), .push_data(y_data),
    .pop(y_pop), .head(y_head), .full(y_full), .empty(y_empty)
  );

  // Configuration registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      delay <= CNT_W'(DELAY_RST);
      mode  <= '0;
    end else begin
      if (delay_wr) delay <= wdata_ext[CNT_W-1:0];
      if (mode_wr)  mode  <= write_data[1:0];
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle clear
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      if (a_push && a_full) ovf_a <= 1'b1;
      else if (ovf_clr)     ovf_a <= 1'b0;
      if (b_push && b_full) ovf_b <= 1'b1;
      else if (ovf_clr)     ovf_b <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!a_empty && !b_empty) state_next = ST_WAIT;
      ST_WAIT: if (fire)                 state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: delay compare is live against the current DELAY register
  always_comb begin
    busy = (state == ST_WAIT);
    fire = busy && (cnt >= delay) && !y_full;
  end

  // Delay counter: runs (saturating) only while waiting, zero otherwise
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (busy && !fire) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Combine operation, MODE sampled at the fire cycle
  always_comb begin
    y_data = '0;
    case (mode)
      2'd0:    y_data = a_head | b_head;
      2'd1:    y_data = a_head & b_head;
      2'd2:    y_data = a_head ^ b_head;
      default: y_data = a_head + b_head;
    endcase
  end

`ifdef DELAYED_OP_STATS_EN
  logic [WIDTH-1:0] fired_cnt;

  // Saturating count of fired results, cleared only by reset
  always_ff @(posedge CLK) begin
    if (!RST_N)                       fired_cnt <= '0;
    else if (fire && fired_cnt != '1) fired_cnt <= fired_cnt + 1'b1;
  end

  assign stats_val = fired_cnt;
`else
  assign stats_val = '0;
`endif

  // Register read mux, zero-extended to WIDTH
  always_comb begin
    read_data = '0;
    case (read_address)
      3'd0:    read_data = WIDTH'(!a_full);
      3'd1:    read_data = WIDTH'(!b_full);
      3'd2:    read_data = WIDTH'(!y_empty);
      3'd3:    read_data = y_empty ? '0 : y_head;
      3'd4:    read_data = delay_ext[WIDTH-1:0];
      3'd5:    read_data = WIDTH'(mode);
      3'd6:    read_data = WIDTH'({ovf_a, ovf_b, busy});
      default: read_data = stats_val;
    endcase
  end
endmodule

// File: tb/tb_delayed_op_dut.sv
// Scoreboard bench for delayed_op_dut: stimulus tasks push expected read
// values into a queue; a negedge monitor pops and compares on each read.
module tb_delayed_op_dut;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] write_address = '0;
  logic [7:0] write_data = '0;
  logic       write_en = 1'b0;
  logic       write_rdy;
  logic [2:0] read_address = '0;
  logic       read_en = 1'b0;
  logic [7:0] read_data;
  logic       read_rdy;
  logic       chk = 1'b0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fires_exp;

  always #5 CLK = ~CLK;

  delayed_op_dut #(.WIDTH(8), .DEPTH(4), .CNT_W(8), .DELAY_RST(50)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy)
  );

  // Monitor: compare every presented read against the scoreboard head
  always @(negedge CLK) begin
    if (chk) begin
      logic [7:0] e;
      string      n;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: read_data=%0h with no expected value", read_data);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_cmp++;
        if (read_data !== e) begin
          n_bad++;
          $display("FAIL %s: read_data=0x%0h expected 0x%0h", n, read_data, e);
        end
        n_cmp++;
        if ({write_rdy, read_rdy} !== 2'b11) begin
          n_bad++;
          $display("FAIL %s_rdy: {write_rdy,read_rdy}=%b expected 11", n, {write_rdy, read_rdy});
        end
      end
    end
  end

  // All tasks start and end 1ns after a rising edge
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    write_address = a;
    write_data    = d;
    write_en      = 1'b1;
    @(posedge CLK); #1;
    write_en      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic pop, input logic [7:0] e, input string n);
    read_address = a;
    read_en      = pop;
    chk          = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge CLK); #1;
    read_en      = 1'b0;
    chk          = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] reset_exp [8];
    reset_exp = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd0};

    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Reset state of the whole register map
    for (int i = 0; i < 8; i++) rd(3'(i), 1'b0, reset_exp[i], $sformatf("reset_addr%0d", i));

    // OR, DELAY=0: result visible exactly two edges after the B push
    wr(6, 8'd0);
    wr(7, 8'd0);
    wr(4, 8'h0F);
    wr(5, 8'hF0);
    rd(2, 1'b0, 8'd0, "or_y_empty_cyc0");
    rd(6, 1'b0, 8'd1, "or_busy_cyc1");
    rd(2, 1'b0, 8'd1, "or_y_ready_cyc2");
    rd(3, 1'b1, 8'hFF, "or_result");
    rd(2, 1'b0, 8'd0, "or_y_drained");
    rd(6, 1'b0, 8'd0, "or_idle");

    // ADD, DELAY=10: result after 12 edges, carry discarded
    wr(6, 8'd10);
    wr(7, 8'd3);
    wr(4, 8'hC8);
    wr(5, 8'h64);
    for (int k = 0; k <= 12; k++) begin
      if (k == 1) rd(6, 1'b0, 8'd1, "add_busy_cyc1");
      else        rd(2, 1'b0, (k == 12) ? 8'd1 : 8'd0, $sformatf("add_y_cyc%0d", k));
    end
    rd(3, 1'b1, 8'h2C, "add_result");
    rd(4, 1'b0, 8'd10, "delay_readback");
    rd(5, 1'b0, 8'd3, "mode_readback");
    fires_exp = 2;
`ifdef DELAYED_OP_STATS_EN
    rd(7, 1'b0, 8'(fires_exp), "stats_after_2");
`else
    rd(7, 1'b0, 8'd0, "stats_absent_2");
`endif

    // Overflow on A: fifth push dropped, flag sticky until read clears it
    for (int i = 1; i <= 5; i++) wr(4, 8'(i));
    rd(0, 1'b0, 8'd0, "a_full");
    rd(1, 1'b0, 8'd1, "b_not_full");
    rd(6, 1'b1, 8'b100, "ovf_a_set");
    rd(6, 1'b1, 8'b000, "ovf_a_cleared");

    // XOR, DELAY=0: fill Y, fifth pair stalls until one pop
    wr(6, 8'd0);
    wr(7, 8'd2);
    wr(5, 8'h10);
    wr(5, 8'h20);
    wr(5, 8'h30);
    wr(5, 8'h40);
    wr(4, 8'h05);
    wr(5, 8'h50);
    idle(12);
    rd(6, 1'b0, 8'd1, "y_full_busy");
    rd(2, 1'b0, 8'd1, "y_full_nonempty");
    rd(0, 1'b0, 8'd1, "a_not_full_stalled");
    rd(6, 1'b0, 8'd1, "y_full_still_busy");
    rd(3, 1'b1, 8'h11, "xor_res1");
    rd(3, 1'b1, 8'h22, "xor_res2");
    rd(3, 1'b1, 8'h33, "xor_res3");
    rd(3, 1'b1, 8'h44, "xor_res4");
    rd(3, 1'b1, 8'h55, "xor_res5");
    rd(2, 1'b0, 8'd0, "xor_y_drained");
    rd(3, 1'b0, 8'd0, "y_head_empty_zero");
    rd(6, 1'b0, 8'd0, "xor_idle");
    fires_exp += 5;

    // AND, DELAY=0
    wr(7, 8'd1);
    wr(4, 8'h3C);
    wr(5, 8'h0F);
    rd(2, 1'b0, 8'd0, "and_y_cyc0");
    rd(2, 1'b0, 8'd0, "and_y_cyc1");
    rd(2, 1'b0, 8'd1, "and_y_cyc2");
    rd(3, 1'b1, 8'h0C, "and_result");
    fires_exp += 1;
`ifdef DELAYED_OP_STATS_EN
    rd(7, 1'b0, 8'(fires_exp), "stats_after_all");
`else
    rd(7, 1'b0, 8'd0, "stats_absent_all");
`endif

    // Reset mid-WAIT discards operands and restores registers
    wr(6, 8'd40);
    wr(4, 8'h09);
    wr(5, 8'h09);
    idle(3);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rd(6, 1'b0, 8'd0, "rst_mid_busy");
    rd(2, 1'b0, 8'd0, "rst_mid_y_empty");
    rd(0, 1'b0, 8'd1, "rst_mid_a_not_full");
    rd(4, 1'b0, 8'd50, "rst_mid_delay");
    rd(5, 1'b0, 8'd0, "rst_mid_mode");
    rd(7, 1'b0, 8'd0, "rst_mid_stats");
    idle(6);
    rd(6, 1'b0, 8'd0, "rst_mid_stays_idle");
    rd(2, 1'b0, 8'd0, "rst_mid_no_result");

    idle(1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
